// File: rtl/gauss_window_ctrl.sv
// Sequencer for the 3x3 Gaussian pipe. It accepts raster pixels, drives the line-buffer
// shift, and emits registered window-valid, border code and centre coordinates.
module gauss_window_ctrl #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             m_ready,
   output logic             lb_shift,
   output logic             win_valid,
   output logic [3:0]       corner_type,
   output logic [CNT_W-1:0] out_row,
   output logic [CNT_W-1:0] out_col,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DRAIN} state_t;

   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] in_row, in_col;
   logic [CNT_W-1:0] win_row, win_col;
   logic [CNT_W-1:0] flush_cnt;

   // Valid/ready: a transfer happens on a cycle where both valid and ready are high;
   // the output window may only be replaced when it is empty or being taken.
   logic win_free, accept, flush_shift, make_win;

   assign win_free    = !win_valid || m_ready;
   assign s_ready     = rst_n && ((state == PRIME) || ((state == RUN) && win_free));
   assign accept      = s_valid && s_ready;
   assign flush_shift = rst_n && (state == FLUSH) && win_free;
   assign lb_shift    = accept || flush_shift;
   assign make_win    = ((state == RUN) && accept) || flush_shift;
   assign busy        = (state != IDLE);

   function automatic logic [3:0] code_of(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] c);
      logic [3:0] code;
      if (r == '0)
         code = (c == '0) ? 4'd1 : (c == LAST_COL) ? 4'd2 : 4'd7;
      else if (r == LAST_ROW)
         code = (c == '0) ? 4'd5 : (c == LAST_COL) ? 4'd6 : 4'd7;
      else
         code = (c == '0) ? 4'd3 : (c == LAST_COL) ? 4'd4 : 4'd8;
      return code;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_row      <= '0;
         in_col      <= '0;
         win_row     <= '0;
         win_col     <= '0;
         flush_cnt   <= '0;
         win_valid   <= 1'b0;
         corner_type <= 4'd0;
         out_row     <= '0;
         out_col     <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         // A new window replaces the current one, even when it is handed over this cycle.
         if (make_win) begin
            win_valid   <= 1'b1;
            corner_type <= code_of(win_row, win_col);
            out_row     <= win_row;
            out_col     <= win_col;
            if (win_col == LAST_COL) begin
               win_col <= '0;
               win_row <= win_row + ONE;
            end else begin
               win_col <= win_col + ONE;
            end
         end else if (win_valid && m_ready) begin
            win_valid   <= 1'b0;
            corner_type <= 4'd0;
         end

         if (accept) begin
            if (in_col == LAST_COL) begin
               in_col <= '0;
               in_row <= in_row + ONE;
            end else begin
               in_col <= in_col + ONE;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= PRIME;
                  in_row    <= '0;
                  in_col    <= '0;
                  win_row   <= '0;
                  win_col   <= '0;
                  flush_cnt <= CNT_W'(IMG_W);
               end
            end
            PRIME: begin
               if (accept && (in_row == ONE) && (in_col == '0))
                  state <= RUN;
            end
            RUN: begin
               if (accept && (in_row == LAST_ROW) && (in_col == LAST_COL))
                  state <= FLUSH;
            end
            FLUSH: begin
               // Counts down from IMG_W so that IMG_W+1 shifts are issued.
               if (flush_shift) begin
                  if (flush_cnt == '0)
                     state <= DRAIN;
                  else
                     flush_cnt <= flush_cnt - ONE;
               end
            end
            DRAIN: begin
               if (win_free) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Bench for gauss_window_ctrl: a 4x3 instance through several frame scenarios and a
// 3x3 instance for the minimum size, with windows scored against an expected queue.
module tb_gauss_window_ctrl;

   localparam int CW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] corner_of(input int r, input int c, input int w, input int h);
      if (r == 0 && c == 0)         return 4'd1;
      if (r == 0 && c == w - 1)     return 4'd2;
      if (r == h - 1 && c == 0)     return 4'd5;
      if (r == h - 1 && c == w - 1) return 4'd6;
      if (r == 0 || r == h - 1)     return 4'd7;
      if (c == 0)                   return 4'd3;
      if (c == w - 1)               return 4'd4;
      return 4'd8;
   endfunction

   // ---------------- 4x3 instance ----------------
   logic          a_rst_n = 1'b0, a_start = 1'b0, a_s_valid = 1'b0, a_m_ready = 1'b1;
   logic          a_s_ready, a_lb_shift, a_win_valid, a_busy, a_frame_done;
   logic [3:0]    a_corner;
   logic [CW-1:0] a_out_row, a_out_col;

   gauss_window_ctrl #(.IMG_W(4), .IMG_H(3), .CNT_W(CW)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .start(a_start), .s_valid(a_s_valid), .s_ready(a_s_ready),
      .m_ready(a_m_ready), .lb_shift(a_lb_shift), .win_valid(a_win_valid),
      .corner_type(a_corner), .out_row(a_out_row), .out_col(a_out_col),
      .busy(a_busy), .frame_done(a_frame_done));

   // ---------------- 3x3 instance ----------------
   logic          b_rst_n = 1'b0, b_start = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b1;
   logic          b_s_ready, b_lb_shift, b_win_valid, b_busy, b_frame_done;
   logic [3:0]    b_corner;
   logic [CW-1:0] b_out_row, b_out_col;

   gauss_window_ctrl #(.IMG_W(3), .IMG_H(3), .CNT_W(CW)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .start(b_start), .s_valid(b_s_valid), .s_ready(b_s_ready),
      .m_ready(b_m_ready), .lb_shift(b_lb_shift), .win_valid(b_win_valid),
      .corner_type(b_corner), .out_row(b_out_row), .out_col(b_out_col),
      .busy(b_busy), .frame_done(b_frame_done));

   // ---------------- scoreboards ----------------
   logic [27:0] exp_a[$];
   logic [27:0] exp_b[$];
   int a_acc, a_wins, a_done, b_acc, b_wins, b_done;
   bit a_seen, b_seen, a_toggle;

   always @(negedge clk) begin
      if (a_rst_n) begin
         if (a_win_valid && !a_seen) begin
            a_seen = 1'b1;
            check("a_first_window_accepts", a_acc, 6);
         end
         if (a_win_valid && a_m_ready) begin
            if (exp_a.size() == 0) check("a_extra_window", 1, 0);
            else check("a_window", {a_corner, a_out_row, a_out_col}, exp_a.pop_front());
            a_wins++;
         end
         if (a_frame_done) a_done++;
         if (a_toggle && !a_s_valid && a_acc < 12) check("a_lb_shift_idle_beat", a_lb_shift, 0);
         if (a_s_valid && a_s_ready) a_acc++;
      end
      if (b_rst_n) begin
         if (b_win_valid && !b_seen) begin
            b_seen = 1'b1;
            check("b_first_window_accepts", b_acc, 5);
         end
         if (b_win_valid && b_m_ready) begin
            if (exp_b.size() == 0) check("b_extra_window", 1, 0);
            else check("b_window", {b_corner, b_out_row, b_out_col}, exp_b.pop_front());
            b_wins++;
         end
         if (b_frame_done) b_done++;
         if (b_s_valid && b_s_ready) b_acc++;
      end
   end

   // mode: 0 continuous, 1 toggling s_valid, 2 stall at (1,1), 3 reset at (1,2), 4 start in flush
   task automatic frame_a(input int mode);
      bit stalled = 1'b0;
      bit restarted = 1'b0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            exp_a.push_back({corner_of(r, c, 4, 3), CW'(r), CW'(c)});
      a_acc = 0; a_wins = 0; a_done = 0; a_seen = 1'b0; a_toggle = (mode == 1);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      for (int cyc = 0; cyc < 300 && a_done == 0; cyc++) begin
         a_s_valid = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
         a_start = 1'b0;
         if (mode == 2 && !stalled && a_win_valid && a_out_row == 1 && a_out_col == 1) begin
            stalled = 1'b1;
            a_m_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_corner", a_corner, 8);
               check("stall_pos", {a_out_row, a_out_col}, {CW'(1), CW'(1)});
               check("stall_s_ready", a_s_ready, 0);
               check("stall_lb_shift", a_lb_shift, 0);
               @(posedge clk); #1;
            end
            a_m_ready = 1'b1;
         end
         if (mode == 3 && a_win_valid && a_out_row == 1 && a_out_col == 2) begin
            a_rst_n = 1'b0;
            @(posedge clk); #1;
            a_rst_n = 1'b1;
            a_s_valid = 1'b0;
            @(negedge clk);
            check("rst_busy", a_busy, 0);
            check("rst_win_valid", a_win_valid, 0);
            check("rst_corner", a_corner, 0);
            check("rst_frame_done", a_frame_done, 0);
            @(posedge clk); #1;
            check("rst_no_done_later", {a_busy, a_frame_done}, 0);
            check("rst_done_count", a_done, 0);
            exp_a.delete();
            return;
         end
         if (mode == 4 && !restarted && a_acc == 12 && a_busy) begin
            restarted = 1'b1;
            a_start = 1'b1;
         end
         @(posedge clk); #1;
      end
      a_start = 1'b0;
      a_s_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("a_frame_done_once", a_done, 1);
      check("a_window_count", a_wins, 12);
      check("a_queue_empty", exp_a.size(), 0);
      check("a_busy_after", a_busy, 0);
      if (mode == 4) check("flush_start_ignored", restarted, 1);
   endtask

   initial begin
      a_s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_s_ready", a_s_ready, 0);
      check("reset_lb_shift", a_lb_shift, 0);
      @(negedge clk);
      check("reset_win_valid", a_win_valid, 0);
      check("reset_corner", a_corner, 0);
      check("reset_pos", {a_out_row, a_out_col}, 0);
      check("reset_busy_done", {a_busy, a_frame_done}, 0);
      @(posedge clk); #1;
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      a_s_valid = 1'b0;
      @(posedge clk); #1;

      frame_a(0);
      frame_a(2);
      frame_a(1);
      frame_a(3);
      frame_a(0);
      frame_a(4);

      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            exp_b.push_back({corner_of(r, c, 3, 3), CW'(r), CW'(c)});
      b_acc = 0; b_wins = 0; b_done = 0; b_seen = 1'b0;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      b_s_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && b_done == 0; cyc++) begin
         @(posedge clk); #1;
      end
      b_s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("b_frame_done_once", b_done, 1);
      check("b_window_count", b_wins, 9);
      check("b_queue_empty", exp_b.size(), 0);
      check("b_busy_after", b_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
